// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a multicycle MIPS-style datapath.
//
// Handles lw, sw, R-type (add/sub/and/or/slt), beq, addi and j. Every memory
// state (FETCH, MEMRD, MEMWR) runs an 8-bit wait counter. Once mem_ready has
// stayed low for MAX_WAIT consecutive cycles, the FSM parks in FAULT. It stays
// there with timeout raised until reset.
//
// Optional feature: define MC_BNE_EN to decode bne (op 000101) through BREX
// with an inverted zero test. Without the macro, bne is an illegal opcode.
//
// Parameters:
//   ALUCTRL_W  alucontrol width (>= 3, upper bits always 0)
//   MAX_WAIT   mem_ready-low cycles tolerated per memory state (1..255)
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   op, funct, zero, mem_ready  opcode, R-type function, ALU zero, memory done
//   mem_req, memwrite           memory request / write strobe
//   irwrite, regwrite, pcen     IR load, register write, PC load
//   iord, alusrca, regdst,
//   memtoreg, alusrcb, pcsrc    datapath mux selects
//   alucontrol                  ALU operation
//   illegal                     one-cycle pulse on unsupported op/funct
//   timeout                     sticky memory timeout flag (FAULT state)
// All outputs are combinational from state plus op/funct/zero/mem_ready.
module multicycle_controller #(
    parameter int unsigned ALUCTRL_W = 3,
    parameter int unsigned MAX_WAIT  = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regwrite,
    output logic                 pcen,
    output logic                 iord,
    output logic                 alusrca,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 illegal,
    output logic                 timeout
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX,
        RTYPEWB, BREX, ADDIEX, ADDIWB, JEX, FAULT
    } state_t;

    state_t           state_q, state_d, out_s;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       alu;
    logic             wait_st;
    logic             expired;

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        mem_req  = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        pcen     = 1'b0;
        iord     = 1'b0;
        alusrca  = 1'b0;
        regdst   = 1'b0;
        memtoreg = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        alu      = ALU_ADD;
        illegal  = 1'b0;
        timeout  = 1'b0;
        state_d  = state_q;

        // While reset is high the outputs already look like FETCH.
        out_s   = reset ? FETCH : state_q;
        expired = !mem_ready && (cnt_q == WAIT_LAST);

        case (out_s)
            FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                if (mem_ready) begin
                    irwrite = 1'b1;
                    pcen    = 1'b1;
                    state_d = DECODE;
                end else if (expired) begin
                    state_d = FAULT;
                end
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BREX;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = BREX;
`endif
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JEX;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = (op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end else if (expired) begin
                    state_d = FAULT;
                end
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
                state_d  = FETCH;
            end
            MEMWR: begin
                mem_req  = 1'b1;
                memwrite = 1'b1;
                iord     = 1'b1;
                if (mem_ready) begin
                    state_d = FETCH;
                end else if (expired) begin
                    state_d = FAULT;
                end
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                state_d = RTYPEWB;
                case (funct)
                    6'b100000: alu = ALU_ADD;
                    6'b100010: alu = ALU_SUB;
                    6'b100100: alu = ALU_AND;
                    6'b100101: alu = ALU_OR;
                    6'b101010: alu = ALU_SLT;
                    default: begin
                        alu     = 3'b000;
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            RTYPEWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
                state_d  = FETCH;
            end
            BREX: begin
                alusrca = 1'b1;
                alu     = ALU_SUB;
                pcsrc   = 2'b01;
                pcen    = zero;
`ifdef MC_BNE_EN
                if (op == OP_BNE) begin
                    pcen = !zero;
                end
`endif
                state_d = FETCH;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
                state_d  = FETCH;
            end
            JEX: begin
                pcsrc   = 2'b10;
                pcen    = 1'b1;
                state_d = FETCH;
            end
            FAULT: begin
                timeout = 1'b1;
                state_d = FAULT;
            end
            default: state_d = FETCH;
        endcase

        alucontrol = ALUCTRL_W'(alu);
    end

    // Wait counter restarts on every state change and counts stalled cycles.
    always_comb begin
        wait_st = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
        cnt_d   = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (wait_st && !mem_ready) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Outputs are packed into one
// vector and compared cycle by cycle against hand-built expected vectors.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       mem_req, memwrite, irwrite, regwrite, pcen;
    logic       iord, alusrca, regdst, memtoreg;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       illegal, timeout;

    int checks = 0;
    int errors = 0;

    multicycle_controller #(.ALUCTRL_W(3), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .pcen(pcen), .iord(iord),
        .alusrca(alusrca), .regdst(regdst), .memtoreg(memtoreg),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .illegal(illegal), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // {mem_req,memwrite,irwrite,regwrite,pcen,iord,alusrca,regdst,memtoreg,
    //  alusrcb,pcsrc,alucontrol,illegal,timeout}
    logic [17:0] obs;
    assign obs = {mem_req, memwrite, irwrite, regwrite, pcen, iord, alusrca,
                  regdst, memtoreg, alusrcb, pcsrc, alucontrol, illegal, timeout};

    localparam logic [17:0] V_FETCH1 = 18'b1_0_1_0_1_0_0_0_0_01_00_010_0_0;
    localparam logic [17:0] V_FETCH0 = 18'b1_0_0_0_0_0_0_0_0_01_00_010_0_0;
    localparam logic [17:0] V_DEC    = 18'b0_0_0_0_0_0_0_0_0_11_00_010_0_0;
    localparam logic [17:0] V_DECILL = 18'b0_0_0_0_0_0_0_0_0_11_00_010_1_0;
    localparam logic [17:0] V_MEMADR = 18'b0_0_0_0_0_0_1_0_0_10_00_010_0_0;
    localparam logic [17:0] V_MEMRD  = 18'b1_0_0_0_0_1_0_0_0_00_00_010_0_0;
    localparam logic [17:0] V_MEMWB  = 18'b0_0_0_1_0_0_0_0_1_00_00_010_0_0;
    localparam logic [17:0] V_MEMWR  = 18'b1_1_0_0_0_1_0_0_0_00_00_010_0_0;
    localparam logic [17:0] V_REX0   = 18'b0_0_0_0_0_0_1_0_0_00_00_000_0_0;
    localparam logic [17:0] V_RILL   = 18'b0_0_0_0_0_0_1_0_0_00_00_000_1_0;
    localparam logic [17:0] V_RWB    = 18'b0_0_0_1_0_0_0_1_0_00_00_010_0_0;
    localparam logic [17:0] V_BR1    = 18'b0_0_0_0_1_0_1_0_0_00_01_110_0_0;
    localparam logic [17:0] V_BR0    = 18'b0_0_0_0_0_0_1_0_0_00_01_110_0_0;
    localparam logic [17:0] V_ADDIWB = 18'b0_0_0_1_0_0_0_0_0_00_00_010_0_0;
    localparam logic [17:0] V_JEX    = 18'b0_0_0_0_1_0_0_0_0_00_10_010_0_0;
    localparam logic [17:0] V_FAULT  = 18'b0_0_0_0_0_0_0_0_0_00_00_010_0_1;

    // Drives a one-cycle reset; leaves the bench 1 time unit after the edge.
    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b0; op = 6'b111111; funct = '0; zero = 1'b0;
        @(posedge clk); #1;
        #1; checks++;
        if (obs !== V_FETCH0) begin errors++; $display("FAIL reset_ready0: got %b expected %b", obs, V_FETCH0); end
        mem_ready = 1'b1;
        #1; checks++;
        if (obs !== V_FETCH1) begin errors++; $display("FAIL reset_ready1: got %b expected %b", obs, V_FETCH1); end
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        #1; checks++;
        if (obs !== V_FETCH0) begin errors++; $display("FAIL after_reset: got %b expected %b", obs, V_FETCH0); end
    endtask

    task automatic test_lw();
        logic [17:0] e [0:5];
        e = '{V_FETCH1, V_DEC, V_MEMADR, V_MEMRD, V_MEMWB, V_FETCH1};
        do_reset();
        op = 6'b100011; mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL lw cycle %0d: got %b expected %b", i, obs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        logic [5:0]  fl [0:4];
        logic [2:0]  al [0:4];
        logic [17:0] e  [0:4];
        fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        al = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        for (int j = 0; j < 5; j++) begin
            e = '{V_FETCH1, V_DEC, V_REX0 | {13'b0, al[j], 2'b00}, V_RWB, V_FETCH1};
            do_reset();
            op = 6'b000000; funct = fl[j]; mem_ready = 1'b1;
            for (int i = 0; i < 5; i++) begin
                #1; checks++;
                if (obs !== e[i]) begin errors++; $display("FAIL rtype funct %b cycle %0d: got %b expected %b", fl[j], i, obs, e[i]); end
                @(posedge clk); #1;
            end
        end
        // Unsupported funct: illegal pulse, no writeback, straight to FETCH.
        e = '{V_FETCH1, V_DEC, V_RILL, V_FETCH1, V_DEC};
        do_reset();
        op = 6'b000000; funct = 6'b000111; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL rtype_illegal cycle %0d: got %b expected %b", i, obs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        logic [17:0] e [0:3];
        for (int z = 1; z >= 0; z--) begin
            e = '{V_FETCH1, V_DEC, (z == 1) ? V_BR1 : V_BR0, V_FETCH1};
            do_reset();
            op = 6'b000100; zero = (z == 1); mem_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                #1; checks++;
                if (obs !== e[i]) begin errors++; $display("FAIL beq zero=%0d cycle %0d: got %b expected %b", z, i, obs, e[i]); end
                @(posedge clk); #1;
            end
        end
        // bne with zero=0 branches only when the option is built in.
`ifdef MC_BNE_EN
        e = '{V_FETCH1, V_DEC, V_BR1, V_FETCH1};
`else
        e = '{V_FETCH1, V_DECILL, V_FETCH1, V_DECILL};
`endif
        do_reset();
        op = 6'b000101; zero = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL bne cycle %0d: got %b expected %b", i, obs, e[i]); end
            @(posedge clk); #1;
        end
        zero = 1'b0;
    endtask

    task automatic test_addi_j_illegal();
        logic [17:0] e [0:4];
        e = '{V_FETCH1, V_DEC, V_MEMADR, V_ADDIWB, V_FETCH1};
        do_reset();
        op = 6'b001000; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL addi cycle %0d: got %b expected %b", i, obs, e[i]); end
            @(posedge clk); #1;
        end
        e = '{V_FETCH1, V_DEC, V_JEX, V_FETCH1, V_DEC};
        do_reset();
        op = 6'b000010;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL j cycle %0d: got %b expected %b", i, obs, e[i]); end
            @(posedge clk); #1;
        end
        e = '{V_FETCH1, V_DECILL, V_FETCH1, V_DECILL, V_FETCH1};
        do_reset();
        op = 6'b111111; mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL illegal_op cycle %0d: got %b expected %b", i, obs, e[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw();
        logic [17:0] e [0:7];
        logic [7:0]  rdy;
        e   = '{V_FETCH1, V_DEC, V_MEMADR, V_MEMWR, V_MEMWR, V_MEMWR, V_MEMWR, V_FETCH1};
        rdy = 8'b1100_0111;
        do_reset();
        op = 6'b101011;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1; checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL sw cycle %0d: got %b expected %b", i, obs, e[i]); end
            @(posedge clk); #1;
        end
        // Reset while parked in MEMWR.
        do_reset();
        mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        #1; checks++;
        if (obs !== V_MEMWR) begin errors++; $display("FAIL sw_wait: got %b expected %b", obs, V_MEMWR); end
        reset = 1'b1;
        #1; checks++;
        if (obs !== V_FETCH0) begin errors++; $display("FAIL sw_in_reset: got %b expected %b", obs, V_FETCH0); end
        @(posedge clk); #1;
        reset = 1'b0;
        #1; checks++;
        if (obs !== V_FETCH0) begin errors++; $display("FAIL sw_after_reset: got %b expected %b", obs, V_FETCH0); end
    endtask

    task automatic test_timeout();
        // FETCH stalls 15 cycles, then FAULT, which ignores mem_ready.
        do_reset();
        op = 6'b000010; mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1; checks++;
            if (obs !== V_FETCH0) begin errors++; $display("FAIL fetch_wait %0d: got %b expected %b", i, obs, V_FETCH0); end
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; checks++;
            if (obs !== V_FAULT) begin errors++; $display("FAIL fault %0d: got %b expected %b", i, obs, V_FAULT); end
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1; checks++;
        if (obs !== V_FETCH1) begin errors++; $display("FAIL fault_reset: got %b expected %b", obs, V_FETCH1); end
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        #1; checks++;
        if (obs !== V_FETCH0) begin errors++; $display("FAIL fault_cleared: got %b expected %b", obs, V_FETCH0); end

        // Ready in the final allowed cycle wins over the timeout.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            mem_ready = (i == 14);
            #1; checks++;
            if (obs !== (i < 14 ? V_FETCH0 : i == 14 ? V_FETCH1 : i == 15 ? V_DEC : V_JEX)) begin
                errors++; $display("FAIL ready_last cycle %0d: got %b", i, obs);
            end
            @(posedge clk); #1;
        end

        // Reset mid-wait restarts the counter from zero.
        do_reset();
        mem_ready = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        do_reset();
        for (int i = 0; i < 16; i++) begin
            #1; checks++;
            if (obs !== (i < 15 ? V_FETCH0 : V_FAULT)) begin
                errors++; $display("FAIL midwait_reset cycle %0d: got %b", i, obs);
            end
            @(posedge clk); #1;
        end

        // MEMRD stall runs its own 15-cycle budget.
        do_reset();
        op = 6'b100011; mem_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1; checks++;
            if (obs !== (i < 15 ? V_MEMRD : V_FAULT)) begin
                errors++; $display("FAIL memrd_timeout cycle %0d: got %b", i, obs);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_branch();
        test_addi_j_illegal();
        test_sw();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALUCTRL_W, default 3, SHALL set alucontrol width; legal values >=3; upper bits beyond [2:0] SHALL be 0.
REQ-002 Parameter MAX_WAIT, default 15, SHALL set the number of consecutive mem_ready-low cycles in a memory state that causes a timeout; legal values 1..255.
REQ-003 Ports (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- op  in  6  instruction opcode.
- funct  in  6  R-type function field.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the access this cycle.
- mem_req  out  1  memory access requested.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  instruction register load.
- regwrite  out  1  register file write.
- pcen  out  1  PC load.
- iord, alusrca, regdst, memtoreg  out  1 each  datapath muxes.
- alusrcb  out  2  ALU B select.
- pcsrc  out  2  PC source select.
- alucontrol  out  ALUCTRL_W  ALU operation.
- illegal  out  1  one-cycle pulse on unsupported op/funct.
- timeout  out  1  sticky memory timeout flag.

Function
REQ-004 Registered Moore FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTYPEEX, RTYPEWB, BREX, ADDIEX, ADDIWB, JEX, FAULT; all outputs combinational from state plus op/funct/zero/mem_ready.
REQ-005 Outputs not listed for a state SHALL be 0; alucontrol defaults to add (010).
REQ-006 FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, pcsrc=00; irwrite=pcen=1 only in the cycle mem_ready=1; go to DECODE on mem_ready, else stay.
REQ-007 DECODE: alusrcb=11, add; next by op: 100011/101011->MEMADR, 000000->RTYPEEX, 000100->BREX, 001000->ADDIEX, 000010->JEX; any other op->FETCH with illegal=1 this cycle.
REQ-008 MEMADR: alusrca=1, alusrcb=10, add; op 100011->MEMRD, else MEMWR.
REQ-009 MEMRD: mem_req=1, iord=1; on mem_ready->MEMWB. MEMWB: regwrite=1, memtoreg=1, regdst=0; ->FETCH.
REQ-010 MEMWR: mem_req=1, memwrite=1, iord=1, held until mem_ready; ->FETCH on mem_ready.
REQ-011 RTYPEEX: alusrca=1, alusrcb=00; funct 100000->010, 100010->110, 100100->000, 100101->001, 101010->111; other funct -> alucontrol 0, illegal=1, next FETCH (no writeback); legal -> RTYPEWB.
REQ-012 RTYPEWB: regwrite=1, regdst=1, memtoreg=0; ->FETCH.
REQ-013 BREX: alusrca=1, alusrcb=00, sub (110), pcsrc=01, pcen=zero for beq; ->FETCH.
REQ-014 ADDIEX: alusrca=1, alusrcb=10, add; ->ADDIWB. ADDIWB: regwrite=1, regdst=0, memtoreg=0; ->FETCH.
REQ-015 JEX: pcsrc=10, pcen=1; ->FETCH.
REQ-016 An 8-bit wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR and increment each cycle in those states with mem_ready=0; when mem_ready=0 and counter==MAX_WAIT-1, next state FAULT.
REQ-017 mem_ready=1 in the timeout cycle SHALL win: normal transition, no fault.
REQ-018 FAULT: all strobes 0, timeout=1, remain until reset.
REQ-019 mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.

Reset
REQ-020 reset=1 at a clock edge SHALL force state FETCH, wait counter 0, timeout 0, from any state including FAULT and mid-wait.
REQ-021 During and after reset, outputs SHALL equal FETCH values with mem_ready as sampled; illegal=0.

Configuration
REQ-022 Macro MC_BNE_EN defined: op 000101 in DECODE SHALL go to BREX with pcen=~zero there, all other BREX outputs as beq.
REQ-023 MC_BNE_EN undefined: op 000101 SHALL be illegal per REQ-007.

Verification
REQ-024 lw (op 100011), mem_ready=1 always -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB (5 cycles); regwrite=1,memtoreg=1 in cycle 5.
REQ-025 add R-type funct 100000 -> alucontrol 010 in RTYPEEX, regwrite=regdst=1 next cycle; funct 000111 -> illegal pulse, no regwrite, back to FETCH.
REQ-026 beq with zero=1 -> pcen=1,pcsrc=01 in BREX; zero=0 -> pcen=0.
REQ-027 FETCH with mem_ready held 0, MAX_WAIT=15 -> FAULT entered after 15 cycles, timeout=1 until reset; ready=1 in cycle 15 -> DECODE instead.
REQ-028 sw with mem_ready low 3 cycles -> memwrite=1 for 4 cycles, then FETCH; reset asserted in MEMWR -> FETCH, memwrite=0 next cycle.
REQ-029 op 000101 -> with MC_BNE_EN, zero=0 gives pcen=1 in BREX; without, illegal=1 in DECODE.
